// File: rtl/pit_io_arbiter.sv
// pit_io_arbiter: round-robin sharing of the PIT I/O request/response stream between N_REQ requesters
module pit_io_arbiter #(
  parameter int N_REQ = 2,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N_REQ-1:0]     req_s_tvalid,
  output logic [N_REQ-1:0]     req_s_tready,
  input  logic [N_REQ*40-1:0]  req_s_tdata,
  output logic [N_REQ-1:0]     rd_m_tvalid,
  input  logic [N_REQ-1:0]     rd_m_tready,
  output logic [15:0]          rd_m_tdata,
  output logic                 io_req_m_tvalid,
  input  logic                 io_req_m_tready,
  output logic [39:0]          io_req_m_tdata,
  input  logic                 io_rd_s_tvalid,
  output logic                 io_rd_s_tready,
  input  logic [15:0]          io_rd_s_tdata
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(LOCK_TIMEOUT + 2);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;
  state_t state, nxt;
  logic [IW-1:0] ptr, owner, gr, gnt, idx;
  logic [CW-1:0] cnt;
  logic lock, hit, hs, done, tmo, expire;
  logic [39:0] rq [N_REQ];
  genvar i;
  for (i = 0; i < N_REQ; i++) begin : g_unpack
    assign rq[i] = req_s_tdata[i*40 +: 40];
  end
  function automatic logic [IW-1:0] inc(input logic [IW-1:0] v);
    return (v == IW'(N_REQ - 1)) ? '0 : v + 1'b1;
  endfunction
  // a held lock restricts eligibility to the owner; otherwise scan forward from ptr
  always_comb begin
    gnt = ptr;
    hit = 1'b0;
    idx = ptr;
    if (lock) begin
      gnt = owner;
      hit = req_s_tvalid[owner];
    end else begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        idx = IW'((int'(ptr) + k) % N_REQ);
        if (req_s_tvalid[idx]) begin
          hit = 1'b1;
          gnt = idx;
        end
      end
    end
  end
  assign hs     = state == IDLE && hit;
  assign done   = (state == ISSUE && io_req_m_tready && io_req_m_tdata[32]) ||
                  (state == RESP && rd_m_tready[gr]);
  assign tmo    = LOCK_TIMEOUT != 0 && state == IDLE && lock && !req_s_tvalid[owner];
  assign expire = tmo && cnt == CW'(LOCK_TIMEOUT - 1);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = hit ? ISSUE : IDLE;
      ISSUE:   nxt = io_req_m_tready ? (io_req_m_tdata[32] ? IDLE : WAIT_RD) : ISSUE;
      WAIT_RD: nxt = io_rd_s_tvalid ? RESP : WAIT_RD;
      default: nxt = rd_m_tready[gr] ? IDLE : RESP;
    endcase
  end
  always_comb begin
    req_s_tready    = (resetn && hs) ? N_REQ'(1) << gnt : '0;
    io_req_m_tvalid = state == ISSUE;
    io_rd_s_tready  = state == WAIT_RD;
    rd_m_tvalid     = (state == RESP) ? N_REQ'(1) << gr : '0;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr            <= '0;
      owner          <= '0;
      gr             <= '0;
      lock           <= 1'b0;
      cnt            <= '0;
      io_req_m_tdata <= '0;
      rd_m_tdata     <= '0;
    end else begin
      if (hs) begin
        io_req_m_tdata <= rq[gnt];
        gr             <= gnt;
      end
      if (state == WAIT_RD && io_rd_s_tvalid) rd_m_tdata <= io_rd_s_tdata;
      if (done) begin
        lock  <= io_req_m_tdata[33];
        owner <= gr;
        ptr   <= io_req_m_tdata[33] ? ptr : inc(gr);
      end
      if (expire) begin
        lock <= 1'b0;
        ptr  <= inc(owner);
      end
      cnt <= (hs || !lock || expire) ? '0 : tmo ? cnt + 1'b1 : cnt;
    end
  end
endmodule

// File: tb/tb_pit_io_arbiter.sv
// tb_pit_io_arbiter: directed tests of pit_io_arbiter against a transaction-level reference model
module tb_pit_io_arbiter;
  localparam int N = 2;
  localparam int LT = 8;
  logic clk, resetn;
  logic [1:0] vld, tready, rd_vld, rd_rdy;
  logic [39:0] rq0, rq1, io_data;
  logic [15:0] rd_data, pit_data;
  logic io_vld, pit_rdy, pit_vld, io_rd_rdy;
  logic [39:0] q0[$], q1[$], sb[$];
  int n_chk = 0, n_fail = 0, s0 = 0, s1 = 0;
  bit stream = 0;
  int m_ph = 0, m_who = 0, m_ptr = 0, m_owner = 0, m_cnt = 0, m_eg = -1;
  bit m_lock = 0, m_fin = 0;
  logic [39:0] m_txn = '0;
  logic [15:0] m_rd = '0;

  pit_io_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .resetn(resetn),
    .req_s_tvalid(vld), .req_s_tready(tready), .req_s_tdata({rq1, rq0}),
    .rd_m_tvalid(rd_vld), .rd_m_tready(rd_rdy), .rd_m_tdata(rd_data),
    .io_req_m_tvalid(io_vld), .io_req_m_tready(pit_rdy), .io_req_m_tdata(io_data),
    .io_rd_s_tvalid(pit_vld), .io_rd_s_tready(io_rd_rdy), .io_rd_s_tdata(pit_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [39:0] mk(input logic l, input logic w, input logic [15:0] a, input logic [15:0] d);
    return {6'b0, l, w, a, d};
  endfunction

  function automatic bit bit_at(input logic [1:0] v, input int j);
    return ((v >> j) & 2'b01) != 2'b00;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply();
    vld[0] = q0.size() > 0;
    vld[1] = q1.size() > 0;
    rq0 = (q0.size() > 0) ? q0[0] : '0;
    rq1 = (q1.size() > 0) ? q1[0] : '0;
  endtask

  task automatic cyc();
    logic [1:0] hs;
    @(negedge clk);
    hs = vld & tready;
    @(posedge clk);
    #1;
    if (hs[0]) void'(q0.pop_front());
    if (hs[1]) void'(q1.pop_front());
    if (stream) begin
      if (q0.size() == 0) begin q0.push_back(mk(0, 1, 16'h0040, 16'(4096 + s0))); s0++; end
      if (q1.size() == 0) begin q1.push_back(mk(0, 1, 16'h0040, 16'(8192 + s1))); s1++; end
    end
    apply();
  endtask

  task automatic do_reset();
    stream = 0;
    q0.delete();
    q1.delete();
    apply();
    resetn = 1'b0;
    repeat (2) cyc();
    resetn = 1'b1;
    sb.delete();
  endtask

  task automatic drain();
    stream = 0;
    q0.delete();
    q1.delete();
    apply();
    repeat (4) cyc();
  endtask

  // every accepted downstream request, in order
  always @(negedge clk) if (resetn && io_vld && pit_rdy) sb.push_back(io_data);

  // reference model: one outstanding transaction, owner-only eligibility while locked, else first valid from the pointer
  always @(negedge clk) begin
    if (!resetn) begin
      m_ph = 0; m_ptr = 0; m_lock = 0; m_owner = 0; m_cnt = 0; m_who = 0; m_txn = '0; m_rd = '0;
      chk("m_rst_ready", 64'(tready), 64'd0);
      chk("m_rst_valids", 64'({io_vld, io_rd_rdy, rd_vld}), 64'd0);
    end else begin
      m_eg = -1;
      if (m_ph == 0) begin
        if (m_lock) begin
          if (bit_at(vld, m_owner)) m_eg = m_owner;
        end else begin
          for (int k = 0; k < N; k++)
            if (m_eg < 0 && bit_at(vld, (m_ptr + k) % N)) m_eg = (m_ptr + k) % N;
        end
      end
      chk("m_req_ready", 64'(tready), 64'(m_eg < 0 ? 2'b00 : 2'b01 << m_eg));
      chk("m_io_valid", 64'(io_vld), 64'(m_ph == 1));
      if (m_ph == 1) chk("m_io_data", 64'(io_data), 64'(m_txn));
      chk("m_io_rd_ready", 64'(io_rd_rdy), 64'(m_ph == 2));
      chk("m_rd_valid", 64'(rd_vld), 64'(m_ph == 3 ? 2'b01 << m_who : 2'b00));
      if (m_ph == 3) chk("m_rd_data", 64'(rd_data), 64'(m_rd));
      m_fin = 0;
      case (m_ph)
        0: begin
          if (m_eg >= 0) begin
            m_txn = (m_eg == 0) ? rq0 : rq1;
            m_who = m_eg;
            m_ph = 1;
            m_cnt = 0;
          end else if (m_lock && !bit_at(vld, m_owner)) begin
            m_cnt++;
            if (m_cnt == LT) begin
              m_lock = 0;
              m_ptr = (m_owner + 1) % N;
              m_cnt = 0;
            end
          end
        end
        1: if (pit_rdy) begin
          if (m_txn[32]) m_fin = 1;
          else m_ph = 2;
        end
        2: if (pit_vld) begin
          m_rd = pit_data;
          m_ph = 3;
        end
        default: if (bit_at(rd_rdy, m_who)) m_fin = 1;
      endcase
      if (m_fin) begin
        m_ph = 0;
        if (m_txn[33]) begin
          m_lock = 1;
          m_owner = m_who;
        end else begin
          m_lock = 0;
          m_ptr = (m_who + 1) % N;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, c0, c1, alt, id;
    resetn = 1'b0;
    pit_rdy = 1'b1;
    pit_vld = 1'b0;
    pit_data = '0;
    rd_rdy = 2'b00;
    apply();
    #2;
    chk("rst_valids", 64'({io_vld, io_rd_rdy, rd_vld, tready}), 64'd0);
    chk("rst_data", 64'({rd_data, io_data}), 64'd0);
    repeat (2) cyc();
    resetn = 1'b1;

    // 1: single write from req0
    q0.push_back(mk(0, 1, 16'h0043, 16'h0036));
    apply();
    #1;
    chk("t1_grant", 64'(tready), 64'h1);
    cyc();
    chk("t1_io_valid", 64'(io_vld), 64'h1);
    chk("t1_io_data", 64'(io_data), 64'h0100430036);
    chk("t1_req1_not_ready", 64'(tready[1]), 64'h0);
    cyc();
    chk("t1_back_idle", 64'(io_vld), 64'h0);

    // 2: read from req1 (pointer now 1), req0 waiting behind it
    q1.push_back(mk(0, 0, 16'h0040, 16'h0000));
    q0.push_back(mk(0, 1, 16'h0043, 16'h1002));
    apply();
    #1;
    chk("t2_ptr_is_1", 64'(tready), 64'h2);
    cyc();
    chk("t2_io_data", 64'(io_data), 64'h0000400000);
    cyc();
    repeat (3) begin
      chk("t2_wait_rd_ready", 64'(io_rd_rdy), 64'h1);
      cyc();
    end
    pit_vld = 1'b1;
    pit_data = 16'h00A5;
    cyc();
    pit_vld = 1'b0;
    chk("t2_rd_data", 64'(rd_data), 64'h00A5);
    for (int k = 0; k < 3; k++) begin
      chk("t2_rd_held", 64'(rd_vld), 64'h2);
      cyc();
    end
    rd_rdy[1] = 1'b1;
    chk("t2_rd_at_ready", 64'(rd_vld), 64'h2);
    cyc();
    rd_rdy[1] = 1'b0;
    chk("t2_rd_cleared", 64'(rd_vld), 64'h0);
    chk("t2_req0_next", 64'(tready), 64'h1);
    drain();

    // 3: both requesters streaming writes from reset
    do_reset();
    stream = 1;
    q0.push_back(mk(0, 1, 16'h0040, 16'(4096 + s0))); s0++;
    q1.push_back(mk(0, 1, 16'h0040, 16'(8192 + s1))); s1++;
    apply();
    for (int c = 0; c < 1000 && sb.size() < 100; c++) cyc();
    chk("t3_100_accepted", 64'(sb.size() >= 100), 64'h1);
    drain();
    if (sb.size() >= 100) begin
      c0 = 0; c1 = 0; alt = 0;
      for (int k = 0; k < 100; k++) begin
        id = int'(sb[k][15:12]);
        if (id == 1) c0++;
        if (id == 2) c1++;
        if (id != (k % 2) + 1) alt++;
      end
      chk("t3_first_is_req0", 64'(sb[0][15:12]), 64'h1);
      chk("t3_order_errors", 64'(alt), 64'd0);
      chk("t3_req0_share", 64'(c0), 64'd50);
      chk("t3_req1_share", 64'(c1), 64'd50);
    end

    // 4: locked three-byte sequence from req0 while req1 is always valid
    do_reset();
    q0.push_back(mk(1, 1, 16'h0043, 16'h0034));
    q0.push_back(mk(1, 1, 16'h0040, 16'h00FF));
    q0.push_back(mk(0, 1, 16'h0040, 16'h0000));
    for (int k = 0; k < 4; k++) q1.push_back(mk(0, 1, 16'h0040, 16'(8192 + k)));
    apply();
    for (int c = 0; c < 100 && sb.size() < 4; c++) cyc();
    chk("t4_four_accepted", 64'(sb.size() >= 4), 64'h1);
    if (sb.size() >= 4) begin
      chk("t4_seq0", 64'(sb[0]), 64'(mk(1, 1, 16'h0043, 16'h0034)));
      chk("t4_seq1", 64'(sb[1]), 64'(mk(1, 1, 16'h0040, 16'h00FF)));
      chk("t4_seq2", 64'(sb[2]), 64'(mk(0, 1, 16'h0040, 16'h0000)));
      chk("t4_req1_next", 64'(sb[3]), 64'(mk(0, 1, 16'h0040, 16'h2000)));
    end
    drain();

    // 5: lock timeout releases req1 after LT idle cycles
    do_reset();
    q0.push_back(mk(1, 1, 16'h0043, 16'h0030));
    q1.push_back(mk(0, 1, 16'h0040, 16'h2001));
    apply();
    cyc();
    cyc();
    n = 1;
    while (!tready[1] && n < 30) begin
      cyc();
      n++;
    end
    chk("t5_grant_idle_cycle", 64'(n), 64'd9);
    drain();

    // 6: asynchronous reset while a read response is pending
    do_reset();
    q0.push_back(mk(0, 0, 16'h0040, 16'h0000));
    q1.push_back(mk(0, 1, 16'h0040, 16'h2002));
    apply();
    cyc();
    cyc();
    chk("t6_wait_rd", 64'(io_rd_rdy), 64'h1);
    pit_vld = 1'b1;
    pit_data = 16'h5A5A;
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_async_rd_ready", 64'(io_rd_rdy), 64'h0);
    chk("t6_async_valids", 64'({io_vld, rd_vld, tready}), 64'h0);
    pit_vld = 1'b0;
    repeat (2) cyc();
    resetn = 1'b1;
    q0.push_back(mk(0, 1, 16'h0043, 16'h1006));
    apply();
    #1;
    chk("t6_data_cleared", 64'({rd_data, io_data}), 64'd0);
    chk("t6_req0_first", 64'(tready), 64'h1);
    cyc();
    chk("t6_req0_issued", 64'(io_data), 64'(mk(0, 1, 16'h0043, 16'h1006)));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
